// File: rtl/calc_pkg.sv
// Shared key codes, operator and FSM state types for the hex calculator.
package calc_pkg;

  localparam logic [4:0] KEY_EQ  = 5'h10;
  localparam logic [4:0] KEY_BS  = 5'h11;
  localparam logic [4:0] KEY_ADD = 5'h12;
  localparam logic [4:0] KEY_SUB = 5'h13;
  localparam logic [4:0] KEY_MUL = 5'h14;
  localparam logic [4:0] KEY_CLR = 5'h15;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_ADD,
    OP_SUB,
    OP_MUL
  } op_t;

  typedef enum logic [1:0] {
    ST_ENTRY,
    ST_SHOW,
    ST_MUL
  } state_t;

  function automatic logic is_op_key(input logic [4:0] code);
    return (code == KEY_ADD) || (code == KEY_SUB) || (code == KEY_MUL);
  endfunction

  // Only meaningful when is_op_key() is true.
  function automatic op_t key_to_op(input logic [4:0] code);
    case (code)
      KEY_ADD: return OP_ADD;
      KEY_SUB: return OP_SUB;
      default: return OP_MUL;
    endcase
  endfunction

endpackage

// File: rtl/calc_mul.sv
// W-cycle shift-add multiplier. One partial product per cycle; done is
// asserted during the last step and product/high_nz show that step's result,
// so the consumer can capture the answer on the same edge the engine stops.
module calc_mul #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         abort,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         done,
  output logic [W-1:0] product,
  output logic         high_nz
);

  localparam int CW = $clog2(W);

  logic           running;
  logic [CW-1:0]  step;
  logic [2*W-1:0] mcand;
  logic [2*W-1:0] prod;
  logic [2*W-1:0] prod_next;
  logic [W-1:0]   mplier;

  // Accumulate the shifted multiplicand when the current multiplier bit is set.
  always_comb prod_next = mplier[0] ? (prod + mcand) : prod;

  assign done    = running && (step == CW'(W - 1));
  assign product = prod_next[W-1:0];
  assign high_nz = |prod_next[2*W-1:W];

  // Load operands on start, then step once per cycle until the last bit.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    if (reset) begin
      running <= 1'b0;
      step    <= '0;
      mcand   <= '0;
      prod    <= '0;
      mplier  <= '0;
    end else if (abort) begin
      running <= 1'b0;
      step    <= '0;
    end else if (start) begin
      running <= 1'b1;
      step    <= '0;
      mcand   <= {{W{1'b0}}, a};
      prod    <= '0;
      mplier  <= b;
    end else if (running) begin
      prod    <= prod_next;
      mcand   <= mcand << 1;
      mplier  <= mplier >> 1;
      step    <= step + CW'(1);
      if (done) running <= 1'b0;
    end
  end

endmodule

// File: rtl/calc_engine.sv
// Hex keypad calculator: digit entry, add/sub/mul with sticky overflow,
// and leading-zero blanking enables for the display. NDIG is 2..16.
module calc_engine
  import calc_pkg::*;
#(
  parameter int NDIG = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                key_valid,
  input  logic [4:0]          key_code,
  output logic                key_ready,
  output logic [4*NDIG-1:0]   disp,
  output logic [NDIG-1:0]     digit_en,
  output logic                busy,
  output logic                ovf
);

  localparam int W    = 4 * NDIG;
  localparam int CNTW = $clog2(NDIG + 1);

  state_t          state, state_d;
  op_t             op, op_d;
  logic [W-1:0]    cur, cur_d;
  logic [W-1:0]    acc, acc_d;
  logic [CNTW-1:0] cnt, cnt_d;
  logic            ovf_d;

  logic            mul_start;
  logic            mul_abort;
  logic            mul_done;
  logic [W-1:0]    mul_product;
  logic            mul_high_nz;

  logic [W:0]      add_full;
  logic            is_digit;
  logic [3:0]      digit;
  logic            nz_seen;

  assign add_full = {1'b0, acc} + {1'b0, cur};
  assign is_digit = ~key_code[4];
  assign digit    = key_code[3:0];

  assign busy      = (state == ST_MUL);
  assign key_ready = ~busy;
  assign disp      = (state == ST_ENTRY) ? cur : acc;

  calc_mul #(.W(W)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .abort   (mul_abort),
    .a       (acc),
    .b       (cur),
    .done    (mul_done),
    .product (mul_product),
    .high_nz (mul_high_nz)
  );

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_ENTRY;
      op    <= OP_NONE;
      cur   <= '0;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_d;
      op    <= op_d;
      cur   <= cur_d;
      acc   <= acc_d;
      cnt   <= cnt_d;
      ovf   <= ovf_d;
    end
  end

  // Key decode, evaluation and next-state logic.
  always_comb begin
    // NOTE: every output of this block gets a default first; any path that
    // skipped an assignment would otherwise infer a latch.
    state_d   = state;
    op_d      = op;
    cur_d     = cur;
    acc_d     = acc;
    cnt_d     = cnt;
    ovf_d     = ovf;
    mul_start = 1'b0;
    mul_abort = 1'b0;

    if (key_valid && key_code == KEY_CLR) begin
      // Clear wins over everything, including a multiply finishing this cycle.
      state_d   = ST_ENTRY;
      op_d      = OP_NONE;
      cur_d     = '0;
      acc_d     = '0;
      cnt_d     = '0;
      ovf_d     = 1'b0;
      mul_abort = 1'b1;
    end else if (state == ST_MUL) begin
      // All other keys are dropped while the multiplier runs.
      if (mul_done) begin
        acc_d   = mul_product;
        ovf_d   = ovf | mul_high_nz;
        state_d = ST_SHOW;
      end
    end else if (key_valid) begin
      case (state)
        ST_ENTRY: begin
          if (is_digit) begin
            // Leading zeros are not entered and do not consume a digit slot.
            if (!(cur == '0 && digit == 4'h0) && cnt != CNTW'(NDIG)) begin
              cur_d = {cur[W-5:0], digit};
              cnt_d = cnt + CNTW'(1);
            end
          end else if (key_code == KEY_BS) begin
            if (cnt != '0) begin
              cur_d = cur >> 4;
              cnt_d = cnt - CNTW'(1);
            end
          end else if (is_op_key(key_code) || key_code == KEY_EQ) begin
            cur_d   = '0;
            cnt_d   = '0;
            op_d    = (key_code == KEY_EQ) ? OP_NONE : key_to_op(key_code);
            state_d = ST_SHOW;
            case (op)
              OP_ADD: begin
                acc_d = add_full[W-1:0];
                ovf_d = ovf | add_full[W];
              end
              OP_SUB: begin
                acc_d = acc - cur;
                ovf_d = ovf | (acc < cur);
              end
              OP_MUL: begin
                mul_start = 1'b1;
                state_d   = ST_MUL;
              end
              default: acc_d = cur;
            endcase
          end
        end
        ST_SHOW: begin
          if (is_digit) begin
            cur_d   = {{(W-4){1'b0}}, digit};
            cnt_d   = (digit != 4'h0) ? CNTW'(1) : '0;
            ovf_d   = 1'b0;
            state_d = ST_ENTRY;
          end else if (is_op_key(key_code)) begin
            op_d = key_to_op(key_code);
          end
        end
        default: ;
      endcase
    end
  end

  // Leading-zero blanking: digit i lights if it or any more significant digit is nonzero.
  always_comb begin
    nz_seen  = 1'b0;
    digit_en = '0;
    for (int i = NDIG - 1; i >= 0; i--) begin
      nz_seen     = nz_seen | (|disp[4*i +: 4]);
      digit_en[i] = nz_seen;
    end
    digit_en[0] = 1'b1;
  end

endmodule

// File: tb/tb_calc_engine.sv
// Directed bench for calc_engine with NDIG=8: table of single-key steps
// plus hand-written multiply, clear-abort and reset-abort sequences.
module tb_calc_engine;

  localparam logic [4:0] K_EQ  = 5'h10;
  localparam logic [4:0] K_BS  = 5'h11;
  localparam logic [4:0] K_ADD = 5'h12;
  localparam logic [4:0] K_SUB = 5'h13;
  localparam logic [4:0] K_MUL = 5'h14;
  localparam logic [4:0] K_CLR = 5'h15;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        key_valid = 1'b0;
  logic [4:0]  key_code = '0;
  logic        key_ready;
  logic [31:0] disp;
  logic [7:0]  digit_en;
  logic        busy;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  calc_engine #(.NDIG(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_ready (key_ready),
    .disp      (disp),
    .digit_en  (digit_en),
    .busy      (busy),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  key;
    logic [31:0] disp;
    logic [7:0]  en;
    logic        ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [4:0] k, input logic [31:0] d, input logic [7:0] e, input logic o);
    vec_t v;
    v.key = k; v.disp = d; v.en = e; v.ovf = o;
    vecs.push_back(v);
  endtask

  // Present a key for one cycle; returns on the falling edge after acceptance.
  task automatic press(input logic [4:0] k);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = k;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  // Count busy cycles, bounded so a stuck multiplier still ends the run.
  task automatic wait_busy(output int n);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int n;

    // Sum of 0x123 + 0x45.
    add_vec(5'h1, 32'h1, 8'h01, 0);
    add_vec(5'h2, 32'h12, 8'h03, 0);
    add_vec(5'h3, 32'h123, 8'h07, 0);
    add_vec(K_ADD, 32'h123, 8'h07, 0);
    add_vec(5'h4, 32'h4, 8'h01, 0);
    add_vec(5'h5, 32'h45, 8'h03, 0);
    add_vec(K_EQ, 32'h168, 8'h07, 0);
    add_vec(K_EQ, 32'h168, 8'h07, 0);   // '=' in SHOW: no-op
    add_vec(K_BS, 32'h168, 8'h07, 0);   // backspace in SHOW: no-op
    add_vec(K_CLR, 32'h0, 8'h01, 0);
    // Full entry, ignored ninth digit, then backspace down to empty.
    add_vec(5'hF, 32'hF, 8'h01, 0);
    add_vec(5'hF, 32'hFF, 8'h03, 0);
    add_vec(5'hF, 32'hFFF, 8'h07, 0);
    add_vec(5'hF, 32'hFFFF, 8'h0F, 0);
    add_vec(5'hF, 32'hFFFFF, 8'h1F, 0);
    add_vec(5'hF, 32'hFFFFFF, 8'h3F, 0);
    add_vec(5'hF, 32'hFFFFFFF, 8'h7F, 0);
    add_vec(5'hF, 32'hFFFFFFFF, 8'hFF, 0);
    add_vec(5'h1, 32'hFFFFFFFF, 8'hFF, 0);
    add_vec(K_BS, 32'h0FFFFFFF, 8'h7F, 0);
    add_vec(K_BS, 32'h00FFFFFF, 8'h3F, 0);
    add_vec(K_BS, 32'h000FFFFF, 8'h1F, 0);
    add_vec(K_BS, 32'h0000FFFF, 8'h0F, 0);
    add_vec(K_BS, 32'h00000FFF, 8'h07, 0);
    add_vec(K_BS, 32'h000000FF, 8'h03, 0);
    add_vec(K_BS, 32'h0000000F, 8'h01, 0);
    add_vec(K_BS, 32'h0, 8'h01, 0);
    add_vec(K_BS, 32'h0, 8'h01, 0);     // empty entry: no-op
    add_vec(5'h0, 32'h0, 8'h01, 0);     // leading zero ignored
    add_vec(5'h1F, 32'h0, 8'h01, 0);    // undefined code
    // Borrow, then a new digit clears ovf.
    add_vec(5'h1, 32'h1, 8'h01, 0);
    add_vec(K_SUB, 32'h1, 8'h01, 0);
    add_vec(5'h2, 32'h2, 8'h01, 0);
    add_vec(K_EQ, 32'hFFFFFFFF, 8'hFF, 1);
    add_vec(5'h7, 32'h7, 8'h01, 0);
    add_vec(5'h16, 32'h7, 8'h01, 0);    // undefined code
    // Operator replaced in SHOW.
    add_vec(K_CLR, 32'h0, 8'h01, 0);
    add_vec(5'h5, 32'h5, 8'h01, 0);
    add_vec(K_ADD, 32'h5, 8'h01, 0);
    add_vec(K_SUB, 32'h5, 8'h01, 0);
    add_vec(5'h3, 32'h3, 8'h01, 0);
    add_vec(K_EQ, 32'h2, 8'h01, 0);
    // Add carry-out: 0xFFFFFFFF + 2.
    add_vec(K_CLR, 32'h0, 8'h01, 0);
    add_vec(K_SUB, 32'h0, 8'h01, 0);
    add_vec(5'h1, 32'h1, 8'h01, 0);
    add_vec(K_ADD, 32'hFFFFFFFF, 8'hFF, 1);
    add_vec(5'h2, 32'h2, 8'h01, 0);
    add_vec(K_EQ, 32'h1, 8'h01, 1);

    // Reset values while reset is held.
    #12;
    check("rst disp", disp, 0);
    check("rst digit_en", digit_en, 8'h01);
    check("rst busy", busy, 0);
    check("rst key_ready", key_ready, 1);
    check("rst ovf", ovf, 0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      press(vecs[i].key);
      check($sformatf("vec%0d disp", i), disp, vecs[i].disp);
      check($sformatf("vec%0d digit_en", i), digit_en, vecs[i].en);
      check($sformatf("vec%0d ovf", i), ovf, vecs[i].ovf);
      check($sformatf("vec%0d key_ready", i), key_ready, 1);
    end

    // 0x10 * 0x10 with digit and operator keys injected while busy.
    press(K_CLR);
    press(5'h1); press(5'h0); press(K_MUL); press(5'h1); press(5'h0); press(K_EQ);
    n = 0;
    while (busy && n < 100) begin
      if (n == 3) begin
        check("mul hold disp", disp, 32'h10);
        check("mul key_ready", key_ready, 0);
      end
      key_valid = (n == 5) || (n == 20);
      key_code  = (n == 20) ? K_ADD : 5'h9;
      n++;
      @(negedge clk);
    end
    key_valid = 1'b0;
    check("mul busy cycles", n, 32);
    check("mul disp", disp, 32'h100);
    check("mul digit_en", digit_en, 8'h07);
    check("mul ovf", ovf, 0);
    press(K_EQ);
    check("mul eq noop", disp, 32'h100);

    // Chained add then multiply: (2+3)*4.
    press(K_CLR);
    press(5'h2); press(K_ADD); press(5'h3); press(K_MUL); press(5'h4); press(K_EQ);
    wait_busy(n);
    check("chain busy cycles", n, 32);
    check("chain disp", disp, 32'h14);

    // Product overflow: 0x10000 * 0x10000 = 2^32.
    press(K_CLR);
    press(5'h1); repeat (4) press(5'h0); press(K_MUL);
    press(5'h1); repeat (4) press(5'h0); press(K_EQ);
    wait_busy(n);
    check("mulovf disp", disp, 32'h0);
    check("mulovf ovf", ovf, 1);

    // Clear aborts a running multiply.
    press(K_CLR);
    press(5'h3); press(K_MUL); press(5'h5); press(K_EQ);
    repeat (4) @(negedge clk);
    check("clr pre busy", busy, 1);
    press(K_CLR);
    check("clr busy", busy, 0);
    check("clr disp", disp, 0);
    check("clr key_ready", key_ready, 1);
    repeat (40) @(negedge clk);
    check("clr late busy", busy, 0);
    check("clr late disp", disp, 0);

    // Reset asserted ten cycles into a multiply.
    press(5'h3); press(K_MUL); press(5'h5); press(K_EQ);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    check("rstmul disp", disp, 0);
    check("rstmul digit_en", digit_en, 8'h01);
    check("rstmul busy", busy, 0);
    check("rstmul key_ready", key_ready, 1);
    check("rstmul ovf", ovf, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    check("rstmul late busy", busy, 0);
    check("rstmul late disp", disp, 0);
    press(K_EQ);
    check("rstmul acc", disp, 0);
    press(5'h7);
    check("rstmul entry", disp, 32'h7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/calc_engine.md
CALC_ENGINE -- requirements
Module: calc_engine

Interface
REQ-001 Parameter NDIG, default 8, number of hex digits; legal range 2..16; W = 4*NDIG is derived, not a parameter.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 key_valid  input  1  one-cycle pulse; key_code is valid this cycle.
REQ-005 key_code  input  5  0x00-0x0F digit, 0x10 '=', 0x11 backspace, 0x12 add, 0x13 sub, 0x14 mul, 0x15 clear; others ignored.
REQ-006 key_ready  output  1  high when a key will be accepted (= !busy).
REQ-007 disp  output  W  value to display.
REQ-008 digit_en  output  NDIG  per-digit display enable for leading-zero blanking.
REQ-009 busy  output  1  multiply in progress.
REQ-010 ovf  output  1  sticky arithmetic overflow/borrow flag.

Function
REQ-011 The FSM SHALL have three states: ENTRY, SHOW, MUL. Registers: cur[W], acc[W], op (NONE/ADD/SUB/MUL), cnt (0..NDIG), ovf.
REQ-012 A digit key in ENTRY SHALL be handled as follows: if cur==0 and key==0, no change; else if cnt==NDIG, the key is ignored; else cur<=(cur<<4)|key and cnt<=cnt+1.
REQ-013 A digit key in SHOW SHALL set cur<=key, cnt<=(key!=0), ovf<=0, and state<=ENTRY.
REQ-014 Backspace in ENTRY with cnt>0 SHALL set cur<=cur>>4 and cnt<=cnt-1; with cnt==0, or in SHOW, it is a no-op.
REQ-015 An operator key (add/sub/mul) in ENTRY SHALL evaluate acc<=f(op,acc,cur), latch op<=new operator, clear cur and cnt, and go to SHOW. f(NONE)=cur.
REQ-016 An operator key in SHOW SHALL only replace op (no evaluation).
REQ-017 '=' in ENTRY SHALL evaluate as in REQ-015, then set op<=NONE and go to SHOW; '=' in SHOW is a no-op.
REQ-018 ADD/SUB evaluation SHALL complete in the acceptance cycle; results are visible the next cycle.
REQ-019 Arithmetic SHALL be modulo 2^W.
REQ-020 ovf SHALL be set on add carry-out, on sub borrow (acc<cur), and on a multiply product with nonzero bits above W-1.
REQ-021 MUL evaluation SHALL enter state MUL and hold busy=1 for exactly W cycles starting the cycle after key acceptance; acc is updated in the cycle busy falls; then the FSM goes to SHOW.
REQ-022 Keys other than clear SHALL be dropped while busy (no queueing).
REQ-023 Clear (0x15) SHALL be accepted in any state, including MUL: it zeroes acc, cur, cnt, and ovf, sets op<=NONE and state<=ENTRY, and aborts any multiply with busy=0 the next cycle.
REQ-024 disp SHALL equal cur in ENTRY and acc in SHOW/MUL; during MUL it holds the pre-multiply acc.
REQ-025 digit_en[0] SHALL be 1 always; digit_en[i] SHALL be 1 when any nibble i..NDIG-1 of disp is nonzero.
REQ-026 A key_valid with an undefined code SHALL change no state.

Reset
REQ-027 Reset SHALL set cur=acc=0, cnt=0, op=NONE, state=ENTRY, ovf=0, and multiplier counters to 0; outputs become disp=0, digit_en=1, busy=0, key_ready=1, ovf=0.
REQ-028 Reset asserted mid-multiply SHALL discard the partial product; no acc update may occur after reset releases.

Structure
REQ-029 Package calc_pkg SHALL hold the key-code constants, op enum, and FSM state enum.
REQ-030 Sub-module calc_mul SHALL implement the W-cycle shift-add multiplier with start/abort/done, a W-bit product, and a high-nonzero flag.
REQ-031 Leading-zero enable generation SHALL be combinational inside calc_engine.

Verification (NDIG=8)
REQ-032 Keys 1,2,3,add,4,5,= -> disp=0x00000168, digit_en=8'b00000111, ovf=0.
REQ-033 Nine keys F,F,F,F,F,F,F,F,1 -> disp=0xFFFFFFFF (ninth key ignored); eight backspaces -> disp=0, digit_en=8'b00000001.
REQ-034 Keys 1,0,mul,1,0,= -> busy high for exactly 32 cycles, then disp=0x100; digit keys during busy are ignored.
REQ-035 Keys 1,sub,2,= -> disp=0xFFFFFFFF, ovf=1; next digit 7 -> ovf=0, disp=7.
REQ-036 Keys 2,add,3,mul,4,= -> disp=0x14; keys 5,add,sub,3,= -> disp=0x2 (operator replaced).
REQ-037 Reset asserted 10 cycles into a multiply -> all outputs at reset values; clear during a multiply -> busy=0 the next cycle, disp=0.
